// File: rtl/ysyx_22040127_lsu_pkg.sv
// Shared definitions for the LSU: funct3 encodings, FSM state type and byte-mask helpers.
package ysyx_22040127_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    // The low two funct3 bits encode the size, so 111 falls through to a doubleword.
    function automatic logic [7:0] size_mask(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] func3, input logic [2:0] offset);
        case (func3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040127_lsu_align.sv
// Load-data aligner: shifts the addressed lane down to bit 0, then sign- or zero-extends by funct3.
module ysyx_22040127_lsu_align
    import ysyx_22040127_lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  logic [2:0]  func3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    // Bytes shifted in from above lane 7 are zero, so misaligned loads read 0 there.
    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (func3)
            F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   result = {56'b0, shifted[7:0]};
            F3_HU:   result = {48'b0, shifted[15:0]};
            F3_WU:   result = {32'b0, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040127_lsu.sv
// Blocking load/store unit between EXU and the pmem model (IDLE -> ACCESS -> RESP).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and respond with resp_err=1.
module ysyx_22040127_lsu
    import ysyx_22040127_lsu_pkg::*;
#(
    parameter logic [63:0] RESET_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata
);

    lsu_state_t  state, next_state;
    logic        wen_q;
    logic [2:0]  func3_q;
    logic [2:0]  off_q;
    logic [63:0] line_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic [63:0] load_data;
    logic        trap_req;
    logic        store_cycle;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign trap_req = misaligned(req_func3, req_addr[2:0]);
    assign resp_err = err_q;
`else
    assign trap_req = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = trap_req ? RESP : ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // line_q only moves for requests that reach ACCESS, so the memory address holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            func3_q <= 3'b000;
            off_q   <= 3'b000;
            line_q  <= RESET_ADDR;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && req_valid) begin
                wen_q   <= req_wen;
                func3_q <= req_func3;
                off_q   <= req_addr[2:0];
                wdata_q <= req_wdata;
                rdata_q <= '0;
                if (!trap_req) line_q <= {req_addr[63:3], 3'b000};
`ifdef LSU_MISALIGN_TRAP_EN
                err_q   <= trap_req;
`endif
            end
            if (state == ACCESS) rdata_q <= wen_q ? '0 : load_data;
        end
    end

    ysyx_22040127_lsu_align u_align (
        .data   (mem_rdata),
        .offset (off_q),
        .func3  (func3_q),
        .result (load_data)
    );

    // Write strobes decode from state alone so reset removes them without a clock.
    assign store_cycle = (state == ACCESS) && wen_q;
    assign mem_wmask   = store_cycle ? (size_mask(func3_q) << off_q) : 8'h00;
    assign mem_wdata   = store_cycle ? (wdata_q << {off_q, 3'b000}) : '0;
    assign mem_waddr   = line_q;
    assign mem_raddr   = line_q;
    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_ysyx_22040127_lsu.sv
// Table-driven bench for ysyx_22040127_lsu with a byte-masked doubleword memory model.
// Honours LSU_MISALIGN_TRAP_EN when choosing expected values.
module tb_ysyx_22040127_lsu;
    import ysyx_22040127_lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [63:0] RESET_ADDR = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_func3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata, mem_waddr, mem_raddr, mem_rdata;

    logic [63:0] mem [0:15];
    int          write_count = 0;
    int          compared = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    ysyx_22040127_lsu #(.RESET_ADDR(RESET_ADDR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_raddr[6:3]];

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] mask);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_wmask != 8'h00) begin
            mem[mem_waddr[6:3]] <= merge(mem[mem_waddr[6:3]], mem_wdata, mem_wmask);
            write_count <= write_count + 1;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                                  input logic [63:0] wdata, output logic [63:0] rdata, output logic err,
                                  output logic [7:0] wmask_seen, output logic [63:0] wdata_seen,
                                  output logic [63:0] waddr_seen, output logic [63:0] raddr_seen,
                                  output int latency);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_output("req_ready before request", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        wmask_seen = 8'h00;
        wdata_seen = '0;
        waddr_seen = '0;
        raddr_seen = '0;
        latency    = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            latency++;
            if (latency == 1) begin
                waddr_seen = mem_waddr;
                raddr_seen = mem_raddr;
            end
            if (mem_wmask != 8'h00) begin
                wmask_seen = wmask_seen | mem_wmask;
                wdata_seen = mem_wdata;
            end
        end while (!resp_valid && latency < 20);
        check_output("resp_valid arrives", {63'b0, resp_valid}, 64'd1);
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] rdata, wdata_seen, waddr_seen, raddr_seen;
        logic        err;
        logic [7:0]  wmask_seen;
        int          latency, wc, k;

        vecs.push_back('{1'b1, F3_D,  64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 8'hFF, 64'h1122_3344_5566_7788});
        vecs.push_back('{1'b0, F3_D,  64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b1, F3_B,  64'h8000_0003, 64'h55AB, 64'h0, 1'b0, 8'h08, 64'h0000_0055_AB00_0000});
        vecs.push_back('{1'b0, F3_B,  64'h8000_0003, 64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_BU, 64'h8000_0003, 64'h0, 64'h0000_0000_0000_00AB, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b1, F3_W,  64'h8000_0004, 64'h8765_4321, 64'h0, 1'b0, 8'hF0, 64'h8765_4321_0000_0000});
        vecs.push_back('{1'b0, F3_W,  64'h8000_0004, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_WU, 64'h8000_0004, 64'h0, 64'h0000_0000_8765_4321, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_H,  64'h8000_0006, 64'h0, 64'hFFFF_FFFF_FFFF_8765, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_HU, 64'h8000_0006, 64'h0, 64'h0000_0000_0000_8765, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_H,  64'h8000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_AB00, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, 3'b111, 64'h8000_0000, 64'h0, 64'h8765_4321_AB00_0000, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b1, F3_H,  64'h8000_0007, 64'hBEEF, 64'h0, TRAP,
                         TRAP ? 8'h00 : 8'h80, TRAP ? 64'h0 : 64'hEF00_0000_0000_0000});
        vecs.push_back('{1'b0, F3_D,  64'h8000_0000, 64'h0,
                         TRAP ? 64'h8765_4321_AB00_0000 : 64'hEF65_4321_AB00_0000, 1'b0, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_W,  64'h8000_0006, 64'h0,
                         TRAP ? 64'h0 : 64'h0000_0000_0000_EF65, TRAP, 8'h00, 64'h0});
        vecs.push_back('{1'b0, F3_B,  64'h8000_0007, 64'h0,
                         TRAP ? 64'hFFFF_FFFF_FFFF_FF87 : 64'hFFFF_FFFF_FFFF_FFEF, 1'b0, 8'h00, 64'h0});

        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'b000;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset req_ready",  {63'b0, req_ready}, 64'd1);
        check_output("reset resp_valid", {63'b0, resp_valid}, 64'd0);
        check_output("reset resp_rdata", resp_rdata, 64'd0);
        check_output("reset resp_err",   {63'b0, resp_err}, 64'd0);
        check_output("reset mem_wmask",  {56'b0, mem_wmask}, 64'd0);
        check_output("reset mem_wdata",  mem_wdata, 64'd0);
        check_output("reset mem_raddr",  mem_raddr, RESET_ADDR);
        check_output("reset mem_waddr",  mem_waddr, RESET_ADDR);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                           rdata, err, wmask_seen, wdata_seen, waddr_seen, raddr_seen, latency);
            check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d err", i), {63'b0, err}, {63'b0, vecs[i].exp_err});
            check_output($sformatf("vec%0d wmask", i), {56'b0, wmask_seen}, {56'b0, vecs[i].exp_wmask});
            check_output($sformatf("vec%0d latency", i), 64'(latency), vecs[i].exp_err ? 64'd1 : 64'd2);
            if (vecs[i].exp_wmask != 8'h00)
                check_output($sformatf("vec%0d wdata", i), wdata_seen, vecs[i].exp_wdata);
            if (!vecs[i].exp_err) begin
                check_output($sformatf("vec%0d waddr", i), waddr_seen, vecs[i].addr & ~64'h7);
                check_output($sformatf("vec%0d raddr", i), raddr_seen, vecs[i].addr & ~64'h7);
            end
        end

        // Response back-pressure: resp_ready low for five cycles.
        req_valid = 1'b1; req_wen = 1'b0; req_func3 = F3_D; req_addr = 64'h8000_0008;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            check_output($sformatf("stall%0d resp_valid", c), {63'b0, resp_valid}, 64'd1);
            check_output($sformatf("stall%0d resp_rdata", c), resp_rdata, 64'h1122_3344_5566_7788);
            check_output($sformatf("stall%0d req_ready", c), {63'b0, req_ready}, 64'd0);
            check_output($sformatf("stall%0d mem_wmask", c), {56'b0, mem_wmask}, 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check_output("after stall req_ready", {63'b0, req_ready}, 64'd1);

        // Asynchronous reset in the middle of a store's ACCESS cycle.
        req_valid = 1'b1; req_wen = 1'b1; req_func3 = F3_D;
        req_addr = 64'h8000_0010; req_wdata = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("abort wmask in ACCESS", {56'b0, mem_wmask}, 64'hFF);
        wc = write_count;
        #1 rst = 1'b1;
        #1;
        check_output("abort mem_wmask",  {56'b0, mem_wmask}, 64'd0);
        check_output("abort mem_wdata",  mem_wdata, 64'd0);
        check_output("abort resp_valid", {63'b0, resp_valid}, 64'd0);
        check_output("abort req_ready",  {63'b0, req_ready}, 64'd1);
        check_output("abort mem_raddr",  mem_raddr, RESET_ADDR);
        check_output("abort resp_rdata", resp_rdata, 64'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort write count", 64'(write_count), 64'(wc));
        check_output("abort memory untouched", mem[2], 64'd0);
        apply_stimulus(1'b0, F3_D, 64'h8000_0010, 64'h0,
                       rdata, err, wmask_seen, wdata_seen, waddr_seen, raddr_seen, latency);
        check_output("post-abort load rdata", rdata, 64'd0);
        check_output("post-abort load latency", 64'(latency), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
